block_ram_reader: RTL and testbench
===================================

# block_ram_reader

Read-out engine for the capture log RAM: on command it sweeps a programmed range of the log RAM's read port and serializes each RAM_WIDTH-bit word into bytes (MSB first) on a valid/ready byte stream toward the UART/host transmit path. It owns the RAM read side (`o_read_adrs`, `o_enbl_read`). `o_enbl_read` is held high for the whole dump, which also holds the logger's write counter at zero.

## Interface
- `RAM_WIDTH`, 32: RAM word width; must be a multiple of 8.
- `RAM_DEPTH`, 32768: RAM words; address width `AW = $clog2(RAM_DEPTH)`.
- `RD_LATENCY`, 1: read latency of the RAM in cycles (1 = LOW_LATENCY, 2 = HIGH_PERFORMANCE).

Ports:
- `clk`  in  1  system clock.
- `i_reset`  in  1  reset, synchronous, active-high.
- `i_start`  in  1  dump request, sampled only in IDLE.
- `i_abort`  in  1  cancel a dump in progress.
- `i_base_adrs`  in  AW  first word address, latched on start.
- `i_num_words`  in  AW+1  number of words to dump, latched on start.
- `i_ram_data`  in  RAM_WIDTH  RAM read data.
- `o_read_adrs`  out  AW  RAM read address.
- `o_enbl_read`  out  1  RAM read enable, high while busy.
- `o_byte`  out  8  stream byte.
- `o_byte_valid`  out  1  byte valid.
- `i_byte_ready`  in  1  downstream ready.
- `o_busy`  out  1  dump in progress.
- `o_done`  out  1  one-cycle pulse when a dump completes normally.

## Operation
- Reset values: all outputs 0; the FSM is in IDLE; the counters are 0.
- The FSM states are IDLE, HDR, READ, WAIT, SEND and DONE.
- IDLE:
  - On `i_start`, latch the base address and word count, and set `o_busy=1` and `o_enbl_read=1`.
  - If the count is 0, go to DONE.
  - Otherwise go to HDR (macro defined) or READ.
- READ: drive `o_read_adrs` with the current address for one cycle, then go to WAIT.
- WAIT: count `RD_LATENCY` cycles. On the last WAIT cycle, register `i_ram_data` into the shift register, set the byte index to 0, and go to SEND.
- SEND:
  - `o_byte` = shift register [RAM_WIDTH-1 -: 8] and `o_byte_valid=1`.
  - On `valid && ready`, shift left by 8.
  - After byte `RAM_WIDTH/8-1`:
    - If words left == 1, go to DONE.
    - Otherwise decrement words left, advance the address, and go to READ.
- Address wrap: `RAM_DEPTH-1` advances to 0.
- DONE: `o_done=1` for one cycle, then `o_busy=0`, `o_enbl_read=0`, return to IDLE.
- `i_start` while busy is ignored.
- `i_abort` in any non-IDLE state:
  - Next cycle: IDLE, `o_byte_valid=0`, `o_busy=0`, `o_enbl_read=0`.
  - No `o_done`; the byte in flight is dropped.
- Abort has priority over a same-cycle handshake.
- `i_reset` mid-dump: same as abort, and all registers go to their reset values.

## Timing
- `i_start` is sampled high at cycle 0.
- READ runs in cycle 1, with `o_read_adrs = base`.
- Data is captured at cycle `1+RD_LATENCY`.
- First `o_byte_valid` is at cycle `2+RD_LATENCY` (macro off).
- Between words: after the last handshake of a word at cycle t, the next word is valid at `t+2+RD_LATENCY`.
- Stream rule: once `o_byte_valid` is high, `o_byte` stays stable and valid stays high until `i_byte_ready`. Valid never depends combinationally on ready.
- With ready held high, one byte is transferred per cycle within a word.
- `o_done` comes one cycle after the final handshake.
- `o_enbl_read` and `o_busy` go low one cycle after `o_done`.

## Configuration
- `BRAM_READER_HEADER_EN` defined:
  - HDR sends 4 bytes before the first word: `0xA5`, `0x5A`, count[15:8], count[7:0].
  - Count is the latched word count, zero-extended or truncated to 16 bits.
  - The header obeys the same valid/ready rules.
  - For a count of 0, the header is sent, then DONE.
  - The first header byte is valid at cycle 1.
- Not defined: no HDR state; the stream carries only data bytes.

## Test plan
- Basic dump:
  - Stimulus: RAM[0..2] = `0x11223344`, `0x55667788`, `0x99AABBCC`; base 0, count 3; ready held high; RD_LATENCY=1.
  - Response: 12 bytes `11 22 33 44 55 … CC`; first valid at cycle 3; one `o_done` pulse.
- Backpressure:
  - Stimulus: ready toggles 1/0 randomly over the same dump.
  - Response: identical byte sequence; `o_byte` stable whenever valid && !ready.
- Wrap-around:
  - Stimulus: base 32767, count 2, RAM[32767]=`0xDEADBEEF`, RAM[0]=`0x01020304`.
  - Response: `DE AD BE EF 01 02 03 04`; address sequence 32767 then 0.
- Edge commands:
  - count 0 → `o_done` at cycle 1 and no bytes (macro off).
  - `i_start` pulsed during a dump → ignored; the byte count is unchanged.
- Abort and reset:
  - `i_abort` after the 5th byte of a 3-word dump → valid low next cycle, no `o_done`, `o_enbl_read` low.
  - `i_reset` mid-SEND → all outputs 0 on the next cycle.
- Header (macro defined), count 3 → stream begins `A5 5A 00 03`, then 12 data bytes; RD_LATENCY=2 variant also checked.

Source files
------------

// File: rtl/block_ram_reader.sv
// rtl/block_ram_reader.sv - capture log RAM read-out engine; header option BRAM_READER_HEADER_EN
module block_ram_reader #(
  parameter int RAM_WIDTH  = 32,
  parameter int RAM_DEPTH  = 32768,
  parameter int RD_LATENCY = 1,
  localparam int AW = $clog2(RAM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic [AW-1:0]        i_base_adrs,
  input  logic [AW:0]          i_num_words,
  input  logic [RAM_WIDTH-1:0] i_ram_data,
  output logic [AW-1:0]        o_read_adrs,
  output logic                 o_enbl_read,
  output logic [7:0]           o_byte,
  output logic                 o_byte_valid,
  input  logic                 i_byte_ready,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int NB = RAM_WIDTH / 8;
  // index also counts the four header bytes, so it is never narrower than 2 bits
  localparam int IW = $clog2(NB + 4);
  localparam int WW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  localparam logic [IW-1:0] LAST_BYTE = IW'(NB - 1);
  localparam logic [WW-1:0] LAST_WAIT = WW'(RD_LATENCY - 1);
  localparam logic [AW-1:0] LAST_ADRS = AW'(RAM_DEPTH - 1);
  localparam logic [AW:0]   ONE_WORD  = (AW + 1)'(1);

  typedef enum logic [2:0] {IDLE, HDR, READ, WAIT, SEND, DONE} state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [AW-1:0]          adrs;
  logic [AW:0]            words_left;
  logic [RAM_WIDTH-1:0]   shreg;
  logic [IW-1:0]          idx;
  logic [WW-1:0]          wait_cnt;
  logic                   cancel;

  // abort only matters once a dump is running
  assign cancel      = i_abort && (state != IDLE);
  assign o_read_adrs = adrs;

`ifdef BRAM_READER_HEADER_EN
  logic [15:0] hdr_count;
  assign hdr_count = 16'(words_left);
`endif

  // state register
  always_ff @(posedge clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  // next state and outputs; every output is decoded from registers only
  always_comb begin
    state_nxt    = state;
    o_byte       = 8'h00;
    o_byte_valid = 1'b0;
    o_done       = 1'b0;
    o_busy       = (state != IDLE);
    o_enbl_read  = (state != IDLE);
    case (state)
      IDLE: begin
        if (i_start) begin
`ifdef BRAM_READER_HEADER_EN
          state_nxt = HDR;
`else
          state_nxt = (i_num_words == '0) ? DONE : READ;
`endif
        end
      end
`ifdef BRAM_READER_HEADER_EN
      HDR: begin
        o_byte_valid = 1'b1;
        case (idx[1:0])
          2'd0:    o_byte = 8'hA5;
          2'd1:    o_byte = 8'h5A;
          2'd2:    o_byte = hdr_count[15:8];
          default: o_byte = hdr_count[7:0];
        endcase
        if (i_byte_ready && idx[1:0] == 2'd3)
          state_nxt = (words_left == '0) ? DONE : READ;
      end
`endif
      READ: state_nxt = WAIT;
      WAIT: begin
        if (wait_cnt == LAST_WAIT) state_nxt = SEND;
      end
      SEND: begin
        o_byte_valid = 1'b1;
        o_byte       = shreg[RAM_WIDTH-1 -: 8];
        if (i_byte_ready && idx == LAST_BYTE)
          state_nxt = (words_left == ONE_WORD) ? DONE : READ;
      end
      DONE: begin
        o_done    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (cancel) state_nxt = IDLE;
  end

  // datapath: address, word count, shift register and small counters
  always_ff @(posedge clk) begin
    if (i_reset) begin
      adrs       <= '0;
      words_left <= '0;
      shreg      <= '0;
      idx        <= '0;
      wait_cnt   <= '0;
    end else if (!cancel) begin
      case (state)
        IDLE: begin
          if (i_start) begin
            adrs       <= i_base_adrs;
            words_left <= i_num_words;
            idx        <= '0;
            wait_cnt   <= '0;
          end
        end
`ifdef BRAM_READER_HEADER_EN
        HDR: begin
          if (i_byte_ready) idx <= idx + 1'b1;
        end
`endif
        READ: wait_cnt <= '0;
        WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (wait_cnt == LAST_WAIT) begin
            shreg <= i_ram_data;
            idx   <= '0;
          end
        end
        SEND: begin
          if (i_byte_ready) begin
            shreg <= shreg << 8;
            idx   <= idx + 1'b1;
            if (idx == LAST_BYTE && words_left != ONE_WORD) begin
              words_left <= words_left - ONE_WORD;
              adrs       <= (adrs == LAST_ADRS) ? '0 : adrs + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_block_ram_reader.sv
// tb/tb_block_ram_reader.sv - directed self-checking bench for block_ram_reader
module tb_block_ram_reader;

`ifdef BRAM_READER_HEADER_EN
  localparam int HDR_N = 4;
`else
  localparam int HDR_N = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        i_reset, i_start, i_abort, byte_ready;
  logic [14:0] base;
  logic [15:0] num;
  logic [31:0] ram [0:32767];

  logic [14:0] adrs1, adrs2;
  logic [31:0] d1, d2a, d2b;
  logic [7:0]  byte1, byte2;
  logic        enbl1, valid1, busy1, done1;
  logic        enbl2, valid2, busy2, done2;

  block_ram_reader #(.RAM_WIDTH(32), .RAM_DEPTH(32768), .RD_LATENCY(1)) dut (
    .clk(clk), .i_reset(i_reset), .i_start(i_start), .i_abort(i_abort),
    .i_base_adrs(base), .i_num_words(num), .i_ram_data(d1),
    .o_read_adrs(adrs1), .o_enbl_read(enbl1), .o_byte(byte1), .o_byte_valid(valid1),
    .i_byte_ready(byte_ready), .o_busy(busy1), .o_done(done1)
  );

  block_ram_reader #(.RAM_WIDTH(32), .RAM_DEPTH(32768), .RD_LATENCY(2)) dut_l2 (
    .clk(clk), .i_reset(i_reset), .i_start(i_start), .i_abort(i_abort),
    .i_base_adrs(base), .i_num_words(num), .i_ram_data(d2b),
    .o_read_adrs(adrs2), .o_enbl_read(enbl2), .o_byte(byte2), .o_byte_valid(valid2),
    .i_byte_ready(byte_ready), .o_busy(busy2), .o_done(done2)
  );

  // RAM models: one-cycle and two-cycle read pipelines
  always @(posedge clk) begin
    d1  <= ram[adrs1];
    d2a <= ram[adrs2];
    d2b <= d2a;
  end

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0]  got[$];
  logic [7:0]  got2[$];
  logic [7:0]  exp[$];
  logic [14:0] adrs_seen[$];
  int first_valid, first_valid2, done_cycle, done_cnt, done2_cnt, stable_bad, last_hs;
  logic [1:0] post_done;
  logic timed_out;

  task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_vec++;
    if (got_v !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got_v, exp_v);
    end
  endtask

  // expected stream: optional header then 4*n bytes taken MSB first from words
  task automatic build_exp(input logic [15:0] cnt, input logic [95:0] words, input int n);
    exp.delete();
`ifdef BRAM_READER_HEADER_EN
    exp.push_back(8'hA5);
    exp.push_back(8'h5A);
    exp.push_back(cnt[15:8]);
    exp.push_back(cnt[7:0]);
`endif
    for (int j = 0; j < 4 * n; j++) exp.push_back(words[95 - 8 * j -: 8]);
  endtask

  task automatic check_stream(input string tag, input logic [7:0] q[$], input int want_n);
    check({tag, "_count"}, q.size(), want_n);
    for (int i = 0; i < q.size() && i < exp.size(); i++) check({tag, "_byte"}, q[i], exp[i]);
  endtask

  task automatic run_dump(input logic [14:0] b, input logic [15:0] n, input int rmode,
                          input int abort_after, input int poke);
    logic       prev_stall;
    logic [7:0] prev_byte;
    logic [15:0] last_adrs;
    int  hs;
    bit  aborting;
    got.delete(); got2.delete(); adrs_seen.delete();
    first_valid = -1; first_valid2 = -1; done_cycle = -1; done_cnt = 0; done2_cnt = 0;
    stable_bad = 0; last_hs = -1; post_done = 2'b11; timed_out = 1'b0;
    prev_stall = 1'b0; prev_byte = 8'h00; last_adrs = 16'hFFFF; hs = 0; aborting = 1'b0;
    base = b; num = n; i_start = 1'b1; byte_ready = (rmode == 0);
    @(negedge clk);
    for (int c = 1; ; c++) begin
      if (c >= 600) begin timed_out = 1'b1; break; end
      if (busy1 && {1'b0, adrs1} != last_adrs) begin
        adrs_seen.push_back(adrs1);
        last_adrs = {1'b0, adrs1};
      end
      if (prev_stall && (!valid1 || byte1 != prev_byte)) stable_bad++;
      if (done1) begin done_cnt++; if (done_cycle < 0) done_cycle = c; end
      if (done2) done2_cnt++;
      if (valid1 && first_valid < 0) first_valid = c;
      if (valid2 && first_valid2 < 0) first_valid2 = c;
      if (done_cycle >= 0 && c == done_cycle + 1) post_done = {busy1, enbl1};
      if (aborting) break;
      if (!busy1 && !busy2) break;
      i_start = (c == poke);
      if (rmode == 1) byte_ready = 1'($urandom_range(0, 1));
      if (abort_after > 0 && hs == abort_after) begin
        i_abort = 1'b1; byte_ready = 1'b1; aborting = 1'b1;
      end
      if (!aborting) begin
        if (valid1 && byte_ready) begin got.push_back(byte1); hs++; last_hs = c; end
        if (valid2 && byte_ready) got2.push_back(byte2);
      end
      prev_stall = valid1 && !byte_ready;
      prev_byte  = byte1;
      @(negedge clk);
    end
    i_start = 1'b0;
    check("timeout", timed_out, 1'b0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_adrs"}, adrs1, 15'd0);
    check({tag, "_enbl"}, enbl1, 1'b0);
    check({tag, "_byte"}, byte1, 8'h00);
    check({tag, "_valid"}, valid1, 1'b0);
    check({tag, "_busy"}, busy1, 1'b0);
    check({tag, "_done"}, done1, 1'b0);
  endtask

  initial begin
    i_reset = 1'b1; i_start = 1'b0; i_abort = 1'b0; byte_ready = 1'b0; base = '0; num = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    i_reset = 1'b0;
    @(negedge clk);

    // basic dump, ready high, stray start pulse at cycle 5
    ram[0] = 32'h11223344; ram[1] = 32'h55667788; ram[2] = 32'h99AABBCC;
    build_exp(16'd3, 96'h11223344_55667788_99AABBCC, 3);
    run_dump(15'd0, 16'd3, 0, 0, 5);
    check_stream("basic", got, 12 + HDR_N);
    check("basic_first_valid", first_valid, (HDR_N > 0) ? 1 : 3);
    check("basic_done_cycle", done_cycle, 19 + HDR_N);
    check("basic_done_cnt", done_cnt, 1);
    check("basic_done_after_last", done_cycle, last_hs + 1);
    check("basic_post_done_busy_enbl", post_done, 2'b00);
    check_stream("lat2", got2, 12 + HDR_N);
    check("lat2_first_valid", first_valid2, (HDR_N > 0) ? 1 : 4);
    check("lat2_done_cnt", done2_cnt, 1);

    // random backpressure on the same dump
    run_dump(15'd0, 16'd3, 1, 0, 0);
    check_stream("bp", got, 12 + HDR_N);
    check("bp_stable", stable_bad, 0);
    check("bp_done_cnt", done_cnt, 1);
    check("bp_done_after_last", done_cycle, last_hs + 1);

    // address wrap from the top word to 0
    ram[32767] = 32'hDEADBEEF; ram[0] = 32'h01020304;
    build_exp(16'd2, {64'hDEADBEEF_01020304, 32'h0}, 2);
    run_dump(15'd32767, 16'd2, 0, 0, 0);
    check_stream("wrap", got, 8 + HDR_N);
    check("wrap_adrs_n", adrs_seen.size(), 2);
    if (adrs_seen.size() == 2) begin
      check("wrap_adrs0", adrs_seen[0], 15'd32767);
      check("wrap_adrs1", adrs_seen[1], 15'd0);
    end

    // zero-word command
    build_exp(16'd0, 96'h0, 0);
    run_dump(15'd0, 16'd0, 0, 0, 0);
    check_stream("zero", got, HDR_N);
    check("zero_done_cycle", done_cycle, 1 + HDR_N);
    check("zero_done_cnt", done_cnt, 1);

    // abort after the fifth byte
    ram[0] = 32'h11223344;
    build_exp(16'd3, 96'h11223344_55667788_99AABBCC, 3);
    run_dump(15'd0, 16'd3, 0, 5, 0);
    check_stream("abort", got, 5);
    check("abort_valid", valid1, 1'b0);
    check("abort_busy", busy1, 1'b0);
    check("abort_enbl", enbl1, 1'b0);
    i_abort = 1'b0;
    repeat (4) begin
      if (done1) done_cnt++;
      @(negedge clk);
    end
    check("abort_no_done", done_cnt, 0);

    // reset in the middle of SEND
    base = 15'd0; num = 16'd3; byte_ready = 1'b1; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    begin
      int k;
      k = 0;
      while (!valid1 && k < 20) begin @(negedge clk); k++; end
      check("rst_reached_send", valid1, 1'b1);
    end
    i_reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("midrst");
    i_reset = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
